// File: rtl/mcu_bus_pkg.sv
// Shared definitions for the MCU byte-bus interface: command codes, FSM states
// and the per-command payload length table.
package mcu_bus_pkg;

    localparam logic [7:0] CMD_SAMPLING_CTRL = 8'h01;
    localparam logic [7:0] CMD_RSVD_05       = 8'h05;
    localparam logic [7:0] CMD_ACQ_STATUS    = 8'h0A;
    localparam logic [7:0] CMD_TIME_BASE     = 8'h0E;
    localparam logic [7:0] CMD_RSVD_0F       = 8'h0F;
    localparam logic [7:0] CMD_TRIG_EDGE     = 8'h16;
    localparam logic [7:0] CMD_TRIG_LEVEL    = 8'h17;
    localparam logic [7:0] CMD_TRIG_MODE     = 8'h1A;
    localparam logic [7:0] CMD_SAMPLING_MODE = 8'h28;

    typedef enum logic [1:0] {
        StIdle,
        StWr,
        StRd
    } bus_state_t;

    typedef struct packed {
        logic [3:0] wr_len;
        logic [3:0] rd_len;
    } cmd_len_t;

    // Reference decode for the external length logic; unknown codes carry no payload.
    function automatic cmd_len_t cmd_lengths(input logic [7:0] cmd);
        cmd_len_t len;
        len = '0;
        case (cmd)
            CMD_SAMPLING_CTRL: len.wr_len = 4'd1;
            CMD_RSVD_05:       len.rd_len = 4'd1;
            CMD_ACQ_STATUS:    len.rd_len = 4'd1;
            CMD_TIME_BASE:     len.wr_len = 4'd4;
            CMD_RSVD_0F:       len.wr_len = 4'd4;
            CMD_TRIG_EDGE:     len.wr_len = 4'd1;
            CMD_TRIG_LEVEL:    len.wr_len = 4'd1;
            CMD_TRIG_MODE:     len.wr_len = 4'd1;
            CMD_SAMPLING_MODE: len.wr_len = 4'd1;
            default:           len = '0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/mcu_bus_sync.sv
// Multi-stage synchronizer for the MCU bus pins with registered rising-edge
// detect on bit 0 (the strobe); the remaining bits are delivered aligned to it.
module mcu_bus_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned WIDTH       = 11,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic             rise
);

    logic [WIDTH-1:0] chain_q [SYNC_STAGES];
    logic [WIDTH-1:0] out_q;
    logic             prev_q;
    logic             rise_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                chain_q[i] <= RESET_VAL;
            end
            out_q  <= RESET_VAL;
            prev_q <= RESET_VAL[0];
            rise_q <= 1'b0;
        end else begin
            chain_q[0] <= async_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                chain_q[i] <= chain_q[i-1];
            end
            out_q  <= chain_q[SYNC_STAGES-1];
            prev_q <= chain_q[SYNC_STAGES-1][0];
            rise_q <= chain_q[SYNC_STAGES-1][0] & ~prev_q;
        end
    end

    assign sync_out = out_q;
    assign rise     = rise_q;

endmodule

// File: rtl/mcu_bus_interface.sv
// Byte-serial MCU bus slave: decodes command bytes, assembles big-endian write
// words and serves read words byte by byte, all in the i_xtal domain.
module mcu_bus_interface
    import mcu_bus_pkg::*;
#(
    parameter int unsigned DATA_BYTES  = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LEN_W       = $clog2(DATA_BYTES + 1)
) (
    input  logic                    i_xtal,
    input  logic                    i_reset_n,
    input  logic                    i_mcu_clk,
    input  logic                    i_mcu_dcs,
    input  logic                    i_mcu_rws,
    input  logic [7:0]              i_mcu_data,
    output logic [7:0]              o_mcu_data,
    output logic                    o_mcu_data_oe,
    output logic [7:0]              o_cmd,
    output logic                    o_cmd_valid,
    input  logic [LEN_W-1:0]        i_wr_len,
    output logic [8*DATA_BYTES-1:0] o_wr_data,
    output logic                    o_wr_valid,
    input  logic [LEN_W-1:0]        i_rd_len,
    input  logic [8*DATA_BYTES-1:0] i_rd_data,
    output logic                    o_rd_ack
);

    localparam int unsigned W = 8 * DATA_BYTES;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_BYTES);
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

    logic [10:0] sync_out;
    logic        edge_seen;
    logic        s_dcs;
    logic        s_rws;
    logic [7:0]  s_data;

    mcu_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES),
        .WIDTH      (11),
        .RESET_VAL  (11'b000_0000_0110)
    ) u_sync (
        .clk     (i_xtal),
        .reset_n (i_reset_n),
        .async_in({i_mcu_data, i_mcu_rws, i_mcu_dcs, i_mcu_clk}),
        .sync_out(sync_out),
        .rise    (edge_seen)
    );

    assign s_dcs  = sync_out[1];
    assign s_rws  = sync_out[2];
    assign s_data = sync_out[10:3];

    bus_state_t       state_q, state_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [W-1:0]     acc_next;
    logic [W-1:0]     hold_q, hold_d;
    logic [W-1:0]     wr_data_q, wr_data_d;
    logic [LEN_W-1:0] wr_idx_q, wr_idx_d;
    logic [LEN_W-1:0] rd_idx_q, rd_idx_d;
    logic [7:0]       cmd_q, cmd_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic             wr_valid_q, wr_valid_d;
    logic             rd_ack_q, rd_ack_d;
    logic             oe_q;
    logic             rws_prev_q;
    logic [LEN_W-1:0] wr_len_eff;
    logic [LEN_W-1:0] rd_len_clamp;
    logic [LEN_W-1:0] rd_len_eff;

    always_comb begin
        wr_len_eff   = (i_wr_len > MAX_LEN) ? MAX_LEN : i_wr_len;
        rd_len_clamp = (i_rd_len > MAX_LEN) ? MAX_LEN : i_rd_len;
        rd_len_eff   = (rd_len_clamp == '0) ? ONE : rd_len_clamp;
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        hold_d      = hold_q;
        wr_data_d   = wr_data_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        cmd_d       = cmd_q;
        cmd_valid_d = 1'b0;
        wr_valid_d  = 1'b0;
        rd_ack_d    = 1'b0;
        acc_next    = '0;

        // Direction flip abandons whatever transfer was in progress.
        if (s_rws != rws_prev_q) begin
            if (state_q == StWr) begin
                acc_d    = '0;
                wr_idx_d = '0;
                state_d  = StIdle;
            end else if (state_q == StRd) begin
                rd_idx_d = '0;
                state_d  = StIdle;
            end
        end

        if (edge_seen) begin
            if (s_dcs && s_rws) begin
                cmd_d       = s_data;
                cmd_valid_d = 1'b1;
                acc_d       = '0;
                wr_idx_d    = '0;
                rd_idx_d    = '0;
                state_d     = StIdle;
            end else if (!s_dcs && s_rws) begin
                if (wr_len_eff != '0) begin
                    acc_next = (acc_d << 8) | W'(s_data);
                    if (wr_idx_d + ONE == wr_len_eff) begin
                        wr_data_d  = acc_next;
                        wr_valid_d = 1'b1;
                        acc_d      = '0;
                        wr_idx_d   = '0;
                        state_d    = StIdle;
                    end else begin
                        acc_d    = acc_next;
                        wr_idx_d = wr_idx_d + ONE;
                        state_d  = StWr;
                    end
                end
            end else if (!s_dcs && !s_rws) begin
                if (rd_idx_d == '0) begin
                    hold_d = i_rd_data;
                end
                if (rd_idx_d + ONE == rd_len_eff) begin
                    rd_ack_d = 1'b1;
                    rd_idx_d = '0;
                    state_d  = StIdle;
                end else begin
                    rd_idx_d = rd_idx_d + ONE;
                    state_d  = StRd;
                end
            end
        end
    end

    always_ff @(posedge i_xtal) begin
        if (!i_reset_n) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            hold_q      <= '0;
            wr_data_q   <= '0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            cmd_q       <= 8'h00;
            cmd_valid_q <= 1'b0;
            wr_valid_q  <= 1'b0;
            rd_ack_q    <= 1'b0;
            oe_q        <= 1'b0;
            rws_prev_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            hold_q      <= hold_d;
            wr_data_q   <= wr_data_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            wr_valid_q  <= wr_valid_d;
            rd_ack_q    <= rd_ack_d;
            oe_q        <= ~s_rws;
            rws_prev_q  <= s_rws;
        end
    end

    // First byte comes from the live word so single-byte polls always see fresh data.
    logic [LEN_W-1:0] byte_sel;
    logic [W-1:0]     rd_src;

    always_comb begin
        byte_sel   = rd_len_eff - ONE - rd_idx_q;
        rd_src     = (rd_idx_q == '0) ? i_rd_data : hold_q;
        o_mcu_data = 8'h00;
        for (int b = 0; b < int'(DATA_BYTES); b++) begin
            if (byte_sel == LEN_W'(b)) begin
                o_mcu_data = rd_src[8*b +: 8];
            end
        end
    end

    assign o_mcu_data_oe = oe_q;
    assign o_cmd         = cmd_q;
    assign o_cmd_valid   = cmd_valid_q;
    assign o_wr_data     = wr_data_q;
    assign o_wr_valid    = wr_valid_q;
    assign o_rd_ack      = rd_ack_q;

endmodule

// File: tb/tb_mcu_bus_interface.sv
// Scoreboard bench for mcu_bus_interface: drives MCU byte transfers on a slow
// strobe and checks commands, write words and read bytes against queued expectations.
module tb_mcu_bus_interface;

    localparam int unsigned DATA_BYTES = 4;
    localparam int unsigned LEN_W      = 3;

    logic        xtal = 1'b0;
    logic        reset_n;
    logic        mcu_clk;
    logic        mcu_dcs;
    logic        mcu_rws;
    logic [7:0]  mcu_data_in;
    logic [7:0]  mcu_data_out;
    logic        mcu_data_oe;
    logic [7:0]  cmd;
    logic        cmd_valid;
    logic [LEN_W-1:0] wr_len;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic [LEN_W-1:0] rd_len;
    logic [31:0] rd_data;
    logic        rd_ack;

    int n_checks = 0;
    int n_errors = 0;
    int wr_cnt   = 0;
    int ack_cnt  = 0;
    int wr_base;
    int ack_base;

    logic [7:0]  exp_cmd [$];
    logic [31:0] exp_wr  [$];

    always #5 xtal = ~xtal;

    mcu_bus_interface #(
        .DATA_BYTES (DATA_BYTES),
        .SYNC_STAGES(2),
        .LEN_W      (LEN_W)
    ) dut (
        .i_xtal       (xtal),
        .i_reset_n    (reset_n),
        .i_mcu_clk    (mcu_clk),
        .i_mcu_dcs    (mcu_dcs),
        .i_mcu_rws    (mcu_rws),
        .i_mcu_data   (mcu_data_in),
        .o_mcu_data   (mcu_data_out),
        .o_mcu_data_oe(mcu_data_oe),
        .o_cmd        (cmd),
        .o_cmd_valid  (cmd_valid),
        .i_wr_len     (wr_len),
        .o_wr_data    (wr_data),
        .o_wr_valid   (wr_valid),
        .i_rd_len     (rd_len),
        .i_rd_data    (rd_data),
        .o_rd_ack     (rd_ack)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge xtal) begin
        if (reset_n) begin
            if (cmd_valid) begin
                if (exp_cmd.size() == 0) check("cmd_unexpected", 64'(exp_cmd.size()), 64'd1);
                else check("cmd", 64'(cmd), 64'(exp_cmd.pop_front()));
            end
            if (wr_valid) begin
                wr_cnt++;
                if (exp_wr.size() == 0) check("wr_unexpected", 64'(exp_wr.size()), 64'd1);
                else check("wr_data", 64'(wr_data), 64'(exp_wr.pop_front()));
            end
            if (rd_ack) ack_cnt++;
        end
    end

    task automatic strobe();
        @(posedge xtal); #1 mcu_clk = 1'b1;
        repeat (6) @(posedge xtal);
        #1 mcu_clk = 1'b0;
        repeat (6) @(posedge xtal);
    endtask

    task automatic mcu_cmd(input logic [7:0] c);
        exp_cmd.push_back(c);
        mcu_dcs = 1'b1; mcu_rws = 1'b1; mcu_data_in = c;
        repeat (6) @(posedge xtal);
        strobe();
    endtask

    task automatic mcu_wr(input logic [7:0] d);
        mcu_dcs = 1'b0; mcu_rws = 1'b1; mcu_data_in = d;
        repeat (6) @(posedge xtal);
        strobe();
    endtask

    task automatic mcu_rd(input string tag, input logic [7:0] exp);
        mcu_dcs = 1'b0; mcu_rws = 1'b0; mcu_data_in = 8'h00;
        repeat (6) @(posedge xtal);
        @(negedge xtal);
        check({tag, "_oe"}, 64'(mcu_data_oe), 64'd1);
        check(tag, 64'(mcu_data_out), 64'(exp));
        strobe();
    endtask

    initial begin
        reset_n = 1'b0; mcu_clk = 1'b0; mcu_dcs = 1'b1; mcu_rws = 1'b1;
        mcu_data_in = 8'h00; wr_len = '0; rd_len = '0; rd_data = '0;
        repeat (4) @(posedge xtal);
        #1 reset_n = 1'b1;
        @(negedge xtal);
        check("rst_cmd", 64'(cmd), 64'h0);
        check("rst_wr_data", 64'(wr_data), 64'h0);
        check("rst_oe", 64'(mcu_data_oe), 64'h0);
        check("rst_pulses", 64'({cmd_valid, wr_valid, rd_ack}), 64'h0);

        // Four-byte time base word.
        wr_base = wr_cnt;
        wr_len = 3'd4;
        mcu_cmd(8'h0E);
        exp_wr.push_back(32'h0006_45DC);
        mcu_wr(8'h00); mcu_wr(8'h06); mcu_wr(8'h45); mcu_wr(8'hDC);
        check("tb_wr_count", 64'(wr_cnt - wr_base), 64'd1);

        // Single-byte payload repeated under one command.
        wr_base = wr_cnt;
        wr_len = 3'd1;
        mcu_cmd(8'h17);
        exp_wr.push_back(32'h19); mcu_wr(8'h19);
        check("lvl_wr_data", 64'(wr_data), 64'h19);
        exp_wr.push_back(32'hAA); mcu_wr(8'hAA);
        exp_wr.push_back(32'hBB); mcu_wr(8'hBB);
        exp_wr.push_back(32'hCC); mcu_wr(8'hCC);
        check("lvl_wr_count", 64'(wr_cnt - wr_base), 64'd4);

        // Partial word discarded by a new command.
        wr_base = wr_cnt;
        wr_len = 3'd4;
        mcu_cmd(8'h0E);
        mcu_wr(8'h00); mcu_wr(8'h06);
        wr_len = 3'd1;
        mcu_cmd(8'h16);
        check("abort_wr_count", 64'(wr_cnt - wr_base), 64'd0);
        check("abort_cmd", 64'(cmd), 64'h16);
        check("abort_wr_hold", 64'(wr_data), 64'hCC);

        // Zero write length ignores data bytes.
        wr_base = wr_cnt;
        wr_len = 3'd0;
        mcu_cmd(8'h05);
        mcu_wr(8'h55); mcu_wr(8'h66);
        check("len0_wr_count", 64'(wr_cnt - wr_base), 64'd0);

        // Oversized write length clamps to DATA_BYTES.
        wr_base = wr_cnt;
        wr_len = 3'd7;
        mcu_cmd(8'h0F);
        exp_wr.push_back(32'h1122_3344);
        mcu_wr(8'h11); mcu_wr(8'h22); mcu_wr(8'h33); mcu_wr(8'h44);
        check("clamp_wr_count", 64'(wr_cnt - wr_base), 64'd1);

        // Status polling returns live data each read.
        ack_base = ack_cnt;
        wr_len = 3'd0; rd_len = 3'd1;
        mcu_cmd(8'h0A);
        rd_data = 32'h0; mcu_rd("poll0", 8'h00);
        rd_data = 32'h0; mcu_rd("poll1", 8'h00);
        rd_data = 32'h1; mcu_rd("poll2", 8'h01);
        check("poll_ack_count", 64'(ack_cnt - ack_base), 64'd3);

        // Two-byte read uses the snapshot after the first byte.
        ack_base = ack_cnt;
        rd_len = 3'd2; rd_data = 32'h1234;
        mcu_rd("rd2_b0", 8'h12);
        rd_data = 32'hFFFF;
        mcu_rd("rd2_b1", 8'h34);
        check("rd2_ack_count", 64'(ack_cnt - ack_base), 64'd1);

        // Direction change in WR drops the partial word.
        wr_base = wr_cnt; ack_base = ack_cnt;
        wr_len = 3'd4; rd_len = 3'd1; rd_data = 32'h5A;
        mcu_cmd(8'h0E);
        mcu_wr(8'hAA); mcu_wr(8'hBB);
        mcu_rd("dir_rd", 8'h5A);
        exp_wr.push_back(32'h0102_0304);
        mcu_wr(8'h01); mcu_wr(8'h02); mcu_wr(8'h03); mcu_wr(8'h04);
        check("dir_wr_count", 64'(wr_cnt - wr_base), 64'd1);
        check("dir_ack_count", 64'(ack_cnt - ack_base), 64'd1);

        // Reset mid-transfer abandons the word.
        wr_base = wr_cnt;
        mcu_cmd(8'h0E);
        mcu_wr(8'hDE); mcu_wr(8'hAD);
        #1 reset_n = 1'b0;
        repeat (3) @(posedge xtal);
        @(negedge xtal);
        check("mid_rst_cmd", 64'(cmd), 64'h0);
        check("mid_rst_wr_data", 64'(wr_data), 64'h0);
        check("mid_rst_oe", 64'(mcu_data_oe), 64'h0);
        #1 reset_n = 1'b1;
        mcu_cmd(8'h0E);
        exp_wr.push_back(32'hCAFE_BABE);
        mcu_wr(8'hCA); mcu_wr(8'hFE); mcu_wr(8'hBA); mcu_wr(8'hBE);
        check("post_rst_wr_count", 64'(wr_cnt - wr_base), 64'd1);
        check("post_rst_wr_data", 64'(wr_data), 64'hCAFE_BABE);

        repeat (4) @(posedge xtal);
        check("cmd_q_left", 64'(exp_cmd.size()), 64'd0);
        check("wr_q_left", 64'(exp_wr.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mcu_bus_interface.md
MCU_BUS_INTERFACE -- requirements
Module: mcu_bus_interface

Interface
REQ-001 Parameter DATA_BYTES, default 4: maximum payload bytes per write or read transfer (1..8).
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth for MCU bus pins (2..4).
REQ-003 Parameter LEN_W, default $clog2(DATA_BYTES+1): width of the length ports.
REQ-004 i_xtal  in  1  sole clock. All logic is rising-edge.
REQ-005 i_reset_n  in  1  reset, synchronous, active-low.
REQ-006 i_mcu_clk  in  1  MCU bus strobe. Async to i_xtal; a rising edge transfers one byte.
REQ-007 i_mcu_dcs  in  1  1 = command byte, 0 = data byte.
REQ-008 i_mcu_rws  in  1  1 = MCU writes, 0 = MCU reads.
REQ-009 i_mcu_data  in  8  MCU-to-FPGA byte.
REQ-010 o_mcu_data  out  8  FPGA-to-MCU byte.
REQ-011 o_mcu_data_oe  out  1  pad output enable.
REQ-012 o_cmd  out  8  last command byte.
REQ-013 o_cmd_valid  out  1  one-cycle pulse on each new command.
REQ-014 i_wr_len  in  LEN_W  payload length for o_cmd. Decoded externally; 0 = no write payload.
REQ-015 o_wr_data  out  8*DATA_BYTES  assembled write word, big-endian, right-aligned.
REQ-016 o_wr_valid  out  1  one-cycle pulse when a write word is complete.
REQ-017 i_rd_len  in  LEN_W  read length for o_cmd.
REQ-018 i_rd_data  in  8*DATA_BYTES  read word supplied by the register/sample logic, right-aligned.
REQ-019 o_rd_ack  out  1  one-cycle pulse after the last byte of a read word.

Function
REQ-020 Synchronization: i_mcu_clk, dcs, rws and data pass through SYNC_STAGES flops; a rising edge is detected on the synchronized clk.
REQ-021 Timing: edge detect to strobe output is one registered cycle, so the total is SYNC_STAGES+2 xtal cycles from the pin edge.
REQ-022 Minimum MCU clk high time and low time is SYNC_STAGES+1 xtal cycles; shorter pulses are unsupported.
REQ-023 Command edge (dcs=1, rws=1):
- latch data to o_cmd;
- pulse o_cmd_valid;
- clear the write and read byte indices;
- discard any partial write word;
- go to IDLE.
REQ-024 FSM states:
- IDLE -> WR on a data-write edge.
- IDLE -> RD on a data-read edge.
- WR -> IDLE on write completion.
- RD -> IDLE on the last read byte.
- Any state -> IDLE on a command edge.
REQ-025 Write edge (dcs=0, rws=1):
- accumulator <= {accumulator, byte};
- write index increments.
REQ-026 Write completion: when the write index reaches the effective length, o_wr_data updates, o_wr_valid pulses and the index returns to 0, so repeated payloads under one command are accepted.
REQ-027 Write length rules: i_wr_len = 0 causes data-write bytes to be ignored; i_wr_len > DATA_BYTES is clamped to DATA_BYTES.
REQ-028 Read edge (dcs=0, rws=0) at read index 0: snapshot i_rd_data into the hold register.
REQ-029 Each read edge increments the read index; at the effective i_rd_len, o_rd_ack pulses and the index returns to 0.
REQ-030 Read length rules: i_rd_len = 0 is treated as 1; values above DATA_BYTES are clamped.
REQ-031 o_mcu_data at read index 0 is byte (len-1) of live i_rd_data; otherwise it is byte (len-1-index) of the hold register.
REQ-032 Polling a 1-byte status with repeated reads therefore returns fresh data each time.
REQ-033 o_mcu_data_oe = NOT synchronized rws, registered.
REQ-034 A change of rws direction while in WR discards the partial write word; a change while in RD clears the read index without o_rd_ack.
REQ-035 o_wr_data holds its value until the next completion.

Reset
REQ-036 On i_reset_n = 0 at a clock edge:
- synchronizers load idle values: clk = 0, dcs = 1, rws = 1;
- o_cmd = 0x00; o_wr_data = 0; all pulses = 0; o_mcu_data_oe = 0;
- indices and hold register = 0;
- FSM = IDLE.
REQ-037 A reset mid-transfer abandons the transfer silently; the first edge after release is decoded normally.

Structure
REQ-038 Package mcu_bus_pkg holds:
- command code constants: 0x01 sampling control, 0x05, 0x0A acquisition status, 0x0E time base, 0x0F, 0x16 trigger edge, 0x17 trigger level, 0x1A trigger mode, 0x28 sampling mode;
- the FSM state enum;
- a function returning write/read length per command.
REQ-039 One sub-module, mcu_bus_sync: a parametrised SYNC_STAGES synchronizer with rising-edge detect.

Verification
REQ-040 Cmd 0x0E, i_wr_len = 4, bytes 00 06 45 DC -> one o_wr_valid pulse, o_wr_data = 0x000645DC.
REQ-041 Cmd 0x17, i_wr_len = 1, byte 0x19 -> o_wr_data = 0x00000019; three further bytes give three more pulses.
REQ-042 Cmd 0x0E, bytes 00 06, then cmd 0x16 -> no o_wr_valid; o_cmd_valid pulses twice; o_cmd = 0x16.
REQ-043 Cmd 0x0A, i_rd_len = 1, i_rd_data 0 -> 0 -> 1 across three reads -> MCU sees 00, 00, 01; three o_rd_ack pulses.
REQ-044 i_rd_len = 2, i_rd_data = 0x1234, changed to 0xFFFF after the first read edge -> MCU reads 12, 34; one o_rd_ack.
REQ-045 Reset asserted after 2 of 4 bytes under cmd 0x0E, then released, then 4 bytes under cmd 0x0E -> exactly one o_wr_valid carrying the second word only.
